comm_ctrl: RTL and testbench

COMM_CTRL -- requirements
Module: comm_ctrl

---
 rtl/comm_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_comm_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_ctrl.sv
// Serial command front-end for a CHANNELS-bit channel enable register.
// Holds the uart_rx/uart_tx byte engines and the comm_ctrl command decoder that uses them.

module uart_rx #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rx,
  output logic [7:0] data,
  output logic       ready
);
  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          ready_q, ready_d;
  logic          rx_s;

  assign rx_s  = sync_q[1];
  assign data  = shreg_q;
  assign ready = ready_q;

  always_ff @(posedge clk) begin
    sync_q    <= {sync_q[0], rx};
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    bit_idx_q <= bit_idx_d;
    shreg_q   <= shreg_d;
    ready_q   <= ready_d;
  end

  // A start bit must still be low at mid-bit, which also rejects power-up glitches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    ready_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RX_IDLE;
          ready_d = rx_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end
endmodule

module uart_tx #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       data_ready,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          done_q, done_d;
  logic          line_n_q, line_d;

  // The line is stored inverted so an unreset register powers up idle-high.
  assign tx   = ~line_n_q;
  assign done = done_q;

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    bit_idx_q <= bit_idx_d;
    shreg_q   <= shreg_d;
    done_q    <= done_d;
    line_n_q  <= ~line_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (data_ready) begin
          shreg_d = data;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = TX_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
    case (state_d)
      TX_START: line_d = 1'b0;
      TX_DATA:  line_d = shreg_d[0];
      default:  line_d = 1'b1;
    endcase
  end
endmodule

module comm_ctrl #(
  parameter int                    CHANNELS     = 16,
  parameter int                    CLK_PER_BIT  = 16,
  parameter logic [CHANNELS-1:0]   RESET_MASK   = {CHANNELS{1'b0}},
  parameter int                    TIMEOUT_CLKS = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                serial_rx,
  output logic                serial_tx,
  output logic [CHANNELS-1:0] enabled_out
);
  localparam int NBYTES = CHANNELS / 8;
  localparam int AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PW     = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(TIMEOUT_CLKS + 1);
  localparam int IW     = $clog2(CHANNELS);

  localparam logic [AW-1:0] ARG_LAST  = AW'(NBYTES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    IDX_LIMIT = 8'(CHANNELS);

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_SET   = 8'h03;
  localparam logic [7:0] OP_CLEAR = 8'h04;
  localparam logic [7:0] ACK      = 8'hAA;
  localparam logic [7:0] NAK      = 8'h55;

  typedef enum logic [2:0] {IDLE, ARG_MASK, ARG_IDX, TX_LOAD, TX_WAIT} state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0] reply_q, reply_d;
  logic [AW-1:0]       arg_cnt_q, arg_cnt_d;
  logic [TW-1:0]       idle_cnt_q, idle_cnt_d;
  logic [PW-1:0]       pending_q, pending_d;
  logic                set_op_q, set_op_d;

  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       data_ready;
  logic [IW-1:0] idx;

  assign enabled_out = mask_q;
  assign data_ready  = (state_q == TX_LOAD);
  assign idx         = rx_data[IW-1:0];

  uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
    .clk   (clk),
    .rx    (serial_rx),
    .data  (rx_data),
    .ready (rx_ready)
  );

  uart_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
    .clk        (clk),
    .data_ready (data_ready),
    .data       (reply_q[7:0]),
    .tx         (serial_tx),
    .done       (tx_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mask_q     <= RESET_MASK;
      shadow_q   <= '0;
      reply_q    <= '0;
      arg_cnt_q  <= '0;
      idle_cnt_q <= '0;
      pending_q  <= '0;
      set_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      shadow_q   <= shadow_d;
      reply_q    <= reply_d;
      arg_cnt_q  <= arg_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      pending_q  <= pending_d;
      set_op_q   <= set_op_d;
    end
  end

  // Replies are shifted out of reply_q LSB-byte first; a READ snapshots the mask at decode.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    shadow_d   = shadow_q;
    reply_d    = reply_q;
    arg_cnt_d  = arg_cnt_q;
    idle_cnt_d = idle_cnt_q;
    pending_d  = pending_q;
    set_op_d   = set_op_q;
    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (rx_ready) begin
          case (rx_data)
            OP_READ: begin
              reply_d   = mask_q;
              pending_d = PW'(NBYTES);
              state_d   = TX_LOAD;
            end
            OP_WRITE: begin
              arg_cnt_d = '0;
              shadow_d  = '0;
              state_d   = ARG_MASK;
            end
            OP_SET, OP_CLEAR: begin
              set_op_d = (rx_data == OP_SET);
              state_d  = ARG_IDX;
            end
            default: begin
              reply_d   = CHANNELS'(NAK);
              pending_d = PW'(1);
              state_d   = TX_LOAD;
            end
          endcase
        end
      end
      ARG_MASK: begin
        if (rx_ready) begin
          idle_cnt_d = '0;
          shadow_d[{arg_cnt_q, 3'b000} +: 8] = rx_data;
          if (arg_cnt_q == ARG_LAST) begin
            mask_d    = shadow_d;
            reply_d   = CHANNELS'(ACK);
            pending_d = PW'(1);
            state_d   = TX_LOAD;
          end else begin
            arg_cnt_d = arg_cnt_q + AW'(1);
          end
        end else if (idle_cnt_q == TO_LAST) begin
          idle_cnt_d = '0;
          arg_cnt_d  = '0;
          shadow_d   = '0;
          state_d    = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
      end
      ARG_IDX: begin
        if (rx_ready) begin
          idle_cnt_d = '0;
          pending_d  = PW'(1);
          state_d    = TX_LOAD;
          if (rx_data < IDX_LIMIT) begin
            mask_d[idx] = set_op_q;
            reply_d     = CHANNELS'(ACK);
          end else begin
            reply_d = CHANNELS'(NAK);
          end
        end else if (idle_cnt_q == TO_LAST) begin
          idle_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
      end
      TX_LOAD: state_d = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) begin
          reply_d   = reply_q >> 8;
          pending_d = pending_q - PW'(1);
          state_d   = (pending_q == PW'(1)) ? IDLE : TX_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_comm_ctrl.sv
// Bench for comm_ctrl: drives command frames, decodes reply frames against a per-DUT expectation queue.
// Runs a 16-channel and a 32-channel instance side by side.

module tb_comm_ctrl;
  localparam int CPB = 16;
  localparam int TO  = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx16, rx32;
  logic        tx16, tx32;
  logic [15:0] mask16;
  logic [31:0] mask32;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp16[$];
  logic [7:0] exp32[$];

  typedef struct {
    logic [7:0]  op;
    bit          has_arg;
    logic [7:0]  arg;
    logic [15:0] mask;
    logic [7:0]  reply;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  comm_ctrl #(.CHANNELS(16), .CLK_PER_BIT(CPB), .RESET_MASK(16'h0000), .TIMEOUT_CLKS(TO)) dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_rx   (rx16),
    .serial_tx   (tx16),
    .enabled_out (mask16)
  );

  comm_ctrl #(.CHANNELS(32), .CLK_PER_BIT(CPB), .RESET_MASK(32'h8000_0001), .TIMEOUT_CLKS(TO)) dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_rx   (rx32),
    .serial_tx   (tx32),
    .enabled_out (mask32)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  function automatic logic getTx(input int which);
    return (which == 0) ? tx16 : tx32;
  endfunction

  function automatic int qSize(input int which);
    return (which == 0) ? exp16.size() : exp32.size();
  endfunction

  task automatic expectByte(input int which, input logic [7:0] b);
    if (which == 0) exp16.push_back(b);
    else            exp32.push_back(b);
  endtask

  task automatic applyStimulus(input int which, input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (which == 0) rx16 = frame[i];
      else            rx32 = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic waitDrained(input int which, input string name);
    int n;
    n = 0;
    while (qSize(which) != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(qSize(which)), 64'd0);
    repeat (3 * CPB) @(negedge clk);
  endtask

  // Decodes every frame on a reply line; each byte is popped from that line's queue.
  task automatic monitorLine(input int which);
    logic [7:0] b;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (getTx(which) === 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge clk);
        if (getTx(which) === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = getTx(which);
          end
          repeat (CPB) @(negedge clk);
          checkOutput((which == 0) ? "stop16" : "stop32", 64'(getTx(which)), 64'd1);
          if (qSize(which) == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected reply on dut%0d: got %h, want none", which, b);
          end else begin
            want = (which == 0) ? exp16.pop_front() : exp32.pop_front();
            checkOutput((which == 0) ? "reply16" : "reply32", 64'(b), 64'(want));
          end
        end
      end
    end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rx16  = 1'b1;
    rx32  = 1'b1;
    rst_n = 1'b0;
    fork
      monitorLine(0);
      monitorLine(1);
    join_none

    vecs[0] = '{8'h03, 1'b1, 8'h00, 16'h1235, 8'hAA};
    vecs[1] = '{8'h04, 1'b1, 8'h04, 16'h1225, 8'hAA};
    vecs[2] = '{8'h03, 1'b1, 8'h10, 16'h1225, 8'h55};
    vecs[3] = '{8'h7F, 1'b0, 8'h00, 16'h1225, 8'h55};
    vecs[4] = '{8'h00, 1'b0, 8'h00, 16'h1225, 8'h55};
    vecs[5] = '{8'h03, 1'b1, 8'h0F, 16'h9225, 8'hAA};
    vecs[6] = '{8'h04, 1'b1, 8'h0C, 16'h8225, 8'hAA};
    vecs[7] = '{8'h04, 1'b1, 8'hFF, 16'h8225, 8'h55};
    vecs[8] = '{8'h05, 1'b0, 8'h00, 16'h8225, 8'h55};

    repeat (5) @(negedge clk);
    checkOutput("reset mask16", 64'(mask16), 64'h0);
    checkOutput("reset mask32", 64'(mask32), 64'h8000_0001);
    checkOutput("idle tx16", 64'(tx16), 64'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] read after reset");
    expectByte(0, 8'h00); expectByte(0, 8'h00);
    applyStimulus(0, 8'h01);
    waitDrained(0, "read after reset");

    $display("[TB] write 0x1234");
    applyStimulus(0, 8'h02);
    applyStimulus(0, 8'h34);
    checkOutput("mask held mid write", 64'(mask16), 64'h0);
    expectByte(0, 8'hAA);
    applyStimulus(0, 8'h12);
    checkOutput("write mask", 64'(mask16), 64'h1234);
    waitDrained(0, "write ack");
    expectByte(0, 8'h34); expectByte(0, 8'h12);
    applyStimulus(0, 8'h01);
    waitDrained(0, "read 0x1234");

    $display("[TB] set/clear table");
    for (int i = 0; i < 9; i++) begin
      expectByte(0, vecs[i].reply);
      applyStimulus(0, vecs[i].op);
      if (vecs[i].has_arg) applyStimulus(0, vecs[i].arg);
      waitDrained(0, "table reply");
      checkOutput("table mask", 64'(mask16), 64'(vecs[i].mask));
    end

    $display("[TB] argument timeout");
    applyStimulus(0, 8'h02);
    applyStimulus(0, 8'hFF);
    repeat (TO + 10) @(negedge clk);
    checkOutput("mask after timeout", 64'(mask16), 64'h8225);
    expectByte(0, 8'h25); expectByte(0, 8'h82);
    applyStimulus(0, 8'h01);
    waitDrained(0, "read after timeout");

    $display("[TB] argument just inside timeout");
    applyStimulus(0, 8'h02);
    applyStimulus(0, 8'hFF);
    repeat (TO - 300) @(negedge clk);
    expectByte(0, 8'hAA);
    applyStimulus(0, 8'h00);
    waitDrained(0, "late arg ack");
    checkOutput("late arg mask", 64'(mask16), 64'h00FF);

    $display("[TB] reset during reply");
    expectByte(0, 8'hFF); expectByte(0, 8'h00);
    applyStimulus(0, 8'h01);
    n = 0;
    while (exp16.size() > 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("first reply byte seen", 64'(exp16.size()), 64'd1);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mask after mid reset", 64'(mask16), 64'h0);
    rst_n = 1'b1;
    repeat (40 * CPB) @(negedge clk);
    checkOutput("reply aborted", 64'(exp16.size()), 64'd0);
    expectByte(0, 8'h00); expectByte(0, 8'h00);
    applyStimulus(0, 8'h01);
    waitDrained(0, "read after mid reset");

    $display("[TB] 32-channel instance");
    expectByte(1, 8'h01); expectByte(1, 8'h00); expectByte(1, 8'h00); expectByte(1, 8'h80);
    applyStimulus(1, 8'h01);
    waitDrained(1, "read32 reset mask");
    applyStimulus(1, 8'h02);
    applyStimulus(1, 8'h78);
    applyStimulus(1, 8'h56);
    applyStimulus(1, 8'h34);
    checkOutput("mask32 held mid write", 64'(mask32), 64'h8000_0001);
    expectByte(1, 8'hAA);
    applyStimulus(1, 8'h12);
    checkOutput("write mask32", 64'(mask32), 64'h1234_5678);
    waitDrained(1, "write32 ack");
    expectByte(1, 8'h78); expectByte(1, 8'h56); expectByte(1, 8'h34); expectByte(1, 8'h12);
    applyStimulus(1, 8'h01);
    waitDrained(1, "read32");
    expectByte(1, 8'hAA);
    applyStimulus(1, 8'h03);
    applyStimulus(1, 8'h1F);
    waitDrained(1, "set32 top");
    checkOutput("mask32 bit31", 64'(mask32), 64'h9234_5678);
    expectByte(1, 8'h55);
    applyStimulus(1, 8'h03);
    applyStimulus(1, 8'h20);
    waitDrained(1, "set32 out of range");
    checkOutput("mask32 unchanged", 64'(mask32), 64'h9234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
